// File: rtl/picorv32_mem_model.sv
// Word-addressed RAM slave for the picorv32 native memory bus.
// Wait-state FSM, byte-strobed writes, out-of-range flag, transfer counters.
module picorv32_mem_model #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] FILL_WORD   = 32'h0000_0013,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err_oob,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] if_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic          oob_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          instr_q;
  logic [3:0]    wait_q;
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   rd_q;
  logic [31:0]   wr_q;
  logic [31:0]   if_q;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] live_idx;
  logic          live_oob;

  assign live_idx = mem_addr[AW+1:2];
  assign live_oob = (mem_addr >> (AW + 2)) != 32'd0;

  // Operands of the access performed at this edge, if any
  logic          go_d;
  logic [AW-1:0] idx_d;
  logic          oob_d;
  logic [31:0]   wdata_d;
  logic [3:0]    wstrb_d;
  logic          instr_d;
  logic          wr_en_d;

  always_comb begin
    go_d    = 1'b0;
    idx_d   = idx_q;
    oob_d   = oob_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (mem_valid && WAIT_STATES == 0) begin
            go_d    = 1'b1;
            idx_d   = live_idx;
            oob_d   = live_oob;
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
            instr_d = mem_instr;
          end
        end
        S_WAIT:  go_d = mem_valid && wait_q == 4'd1;
        default: go_d = 1'b0;
      endcase
    end
  end

  assign wr_en_d = go_d && wstrb_d != 4'd0 && !oob_d;

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_d[b]) begin
          mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      rd_q    <= 32'd0;
      wr_q    <= 32'd0;
      if_q    <= 32'd0;
      wait_q  <= 4'd0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            idx_q   <= live_idx;
            oob_q   <= live_oob;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
            wait_q  <= 4'(WAIT_STATES);
            state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q - 4'd1;
            if (wait_q == 4'd1) state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (go_d) begin
        ready_q <= 1'b1;
        if (oob_d) err_q <= 1'b1;
        if (wstrb_d == 4'd0) begin
          rdata_q <= oob_d ? FILL_WORD : mem_q[idx_d];
          rd_q    <= rd_q + 32'd1;
          if (instr_d) if_q <= if_q + 32'd1;
        end else begin
          rdata_q <= 32'd0;
          wr_q    <= wr_q + 32'd1;
        end
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign err_oob   = err_q;
  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign if_count  = if_q;

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Scoreboard bench for picorv32_mem_model at zero and three wait states.
// Random bus traffic is scored against an array model of the memory.
module tb_picorv32_mem_model;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    int          at;
    logic [31:0] rd;
    logic [31:0] wr;
    logic [31:0] ifc;
    logic        err;
  } exp_t;

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h want=%h",
               nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int unsigned WS = (g == 0) ? 0 : 3;

    logic        rst;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rdc;
    logic [31:0] wrc;
    logic [31:0] ifc;

    logic [31:0] m [DEPTH];
    logic [31:0] e_rd;
    logic [31:0] e_wr;
    logic [31:0] e_if;
    logic        e_err;
    exp_t        sb [$];
    exp_t        mon_e;
    bit          rdy_now;
    bit          done = 1'b0;

    picorv32_mem_model #(
      .DEPTH      (DEPTH),
      .WAIT_STATES(WS)
    ) dut (
      .clk      (clk),
      .reset    (rst),
      .mem_valid(valid),
      .mem_instr(instr),
      .mem_addr (addr),
      .mem_wdata(wdata),
      .mem_wstrb(wstrb),
      .mem_ready(ready),
      .mem_rdata(rdata),
      .err_oob  (err),
      .rd_count (rdc),
      .wr_count (wrc),
      .if_count (ifc)
    );

    always @(negedge clk) begin
      if (ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready inst=%0d got=1 want=0 cyc=%0d",
                   g, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", g, 32'(cyc), 32'(mon_e.at));
          chk("rdata", g, rdata, mon_e.rdata);
          chk("rd_count", g, rdc, mon_e.rd);
          chk("wr_count", g, wrc, mon_e.wr);
          chk("if_count", g, ifc, mon_e.ifc);
          chk("err_oob", g, 32'(err), 32'(mon_e.err));
        end
      end
    end

    task automatic model_access(input logic [31:0] a, d,
                                input logic [3:0] s,
                                input logic i,
                                output exp_t e);
      bit oob;
      int idx;
      oob = a >= LIMIT;
      idx = int'((a >> 2) & 32'(DEPTH - 1));
      if (oob) e_err = 1'b1;
      if (s == 4'd0) begin
        e.rdata = oob ? 32'h0000_0013 : m[idx];
        e_rd++;
        if (i) e_if++;
      end else begin
        e.rdata = 32'd0;
        e_wr++;
        if (!oob) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) m[idx][8*b +: 8] = d[8*b +: 8];
        end
      end
      e.rd  = e_rd;
      e.wr  = e_wr;
      e.ifc = e_if;
      e.err = e_err;
      e.at  = 0;
    endtask

    task automatic xfer(input logic [31:0] a, d,
                        input logic [3:0] s,
                        input logic i);
      exp_t e;
      bit   seen;
      addr  = a;
      wdata = d;
      wstrb = s;
      instr = i;
      valid = 1'b1;
      model_access(a, d, s, i, e);
      // a request raised in the response cycle waits one extra edge
      e.at = cyc + (rdy_now ? 2 : 1) + int'(WS);
      sb.push_back(e);
      seen = 1'b0;
      for (int n = 0; n < int'(WS) + 4; n++) begin
        @(negedge clk);
        if (ready) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL ready_timeout inst=%0d got=0 want=1 addr=%h",
                 g, a);
      end
      rdy_now = seen;
    endtask

    task automatic idle(input int n);
      valid   = 1'b0;
      rdy_now = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    initial begin
      logic [31:0] a;
      logic [3:0]  s;
      rst     = 1'b1;
      valid   = 1'b0;
      instr   = 1'b0;
      addr    = 32'd0;
      wdata   = 32'd0;
      wstrb   = 4'd0;
      rdy_now = 1'b0;
      e_rd    = 32'd0;
      e_wr    = 32'd0;
      e_if    = 32'd0;
      e_err   = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_ready", g, 32'(ready), 32'd0);
      chk("rst_rdata", g, rdata, 32'd0);
      chk("rst_err", g, 32'(err), 32'd0);
      chk("rst_rd", g, rdc, 32'd0);
      chk("rst_wr", g, wrc, 32'd0);
      chk("rst_if", g, ifc, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < int'(DEPTH); i++)
        xfer(32'(i * 4), $urandom, 4'hF, 1'b0);
      idle(1);

      xfer(32'h4, 32'hDEADBEEF, 4'hF, 1'b0);
      xfer(32'h8, 32'hAABBCCDD, 4'hF, 1'b0);
      idle(1);
      xfer(32'h4, 32'd0, 4'h0, 1'b1);
      chk("fetch_word", g, rdata, 32'hDEADBEEF);
      idle(2);
      xfer(32'h8, 32'h11223344, 4'b0011, 1'b0);
      xfer(32'h8, 32'd0, 4'h0, 1'b0);
      chk("strb_merge", g, rdata, 32'hAABB3344);
      idle(1);

      xfer(LIMIT, 32'd0, 4'h0, 1'b1);
      chk("oob_fill", g, rdata, 32'h0000_0013);
      chk("oob_flag", g, 32'(err), 32'd1);
      xfer(LIMIT, 32'h5555AAAA, 4'hF, 1'b0);
      xfer(32'h0, 32'd0, 4'h0, 1'b0);
      xfer(32'hFFFF_FFFC, 32'd0, 4'h0, 1'b0);
      idle(1);

      if (WS != 0) begin
        addr  = 32'h10;
        wdata = $urandom;
        wstrb = 4'hF;
        instr = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        xfer(32'h10, 32'd0, 4'h0, 1'b0);
        idle(1);
        wdata = $urandom;
        valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        e_rd  = 32'd0;
        e_wr  = 32'd0;
        e_if  = 32'd0;
        e_err = 1'b0;
      end
      xfer(32'h10, 32'd0, 4'h0, 1'b0);
      idle(1);

      repeat (200) begin
        if ($urandom_range(0, 7) == 0)
          a = LIMIT + ($urandom & 32'h00FF_FFFF);
        else
          a = 32'($urandom_range(0, 4 * DEPTH - 1));
        s = ($urandom_range(0, 1) == 0) ? 4'h0
                                        : 4'($urandom_range(1, 15));
        xfer(a, $urandom, s, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      end
      idle(int'(WS) + 4);
      chk("drain", g, 32'(sb.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (gi[0].done && gi[1].done) break;
    end
    checks++;
    if (!(gi[0].done && gi[1].done)) begin
      failures++;
      $display("FAIL global_timeout got=%0b%0b want=11",
               gi[0].done, gi[1].done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
